seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive side of the multiplexed seven-segment display interface (AN anode strobes, CT cathodes) driven by the CPU top level.
- Samples the scanned AN/CT lines and rejects transition glitches.
- Decodes each lit digit back to a hex nibble and reassembles a complete display frame into one word.
- Used as an on-chip or bench-side self-check monitor of what the CPU shows on the display.

Parameters:
- NUM_DIGITS, 8: number of multiplexed digits, equal to the AN width.
- STABLE_CYCLES, 4: consecutive identical cycles required before a digit is captured; must be at least 1.
- TIMEOUT_CYCLES, 1048576: maximum number of cycles allowed between captures before a partial frame is abandoned.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- an_i, input, NUM_DIGITS: anode strobes, active-low; bit k selects digit k.
- ct_i, input, 8: cathodes, active-low; bit0 = segment a through bit6 = segment g, bit7 = dp.
- word_o, output, 4*NUM_DIGITS: decoded frame; digit k occupies bits [4k+3:4k].
- blank_mask_o, output, NUM_DIGITS: bit k = digit k was blank in the frame.
- dp_mask_o, output, NUM_DIGITS: bit k = decimal point k was lit.
- word_valid_o, output, 1: one-cycle pulse when a frame completes.
- err_o, output, 1: valid with word_valid_o; 1 if any digit in the frame had an undecodable pattern.
- timeout_o, output, 1: one-cycle pulse when a partial frame is abandoned.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: every output is 0. Reset also clears the stable counter, the seen mask, the slot storage, the captured flag and the timeout counter.
- A reset asserted mid-frame discards the partial frame; no pulse is produced.
- Inputs are registered once before use. All rules below apply to the registered values.
- Eligible cycle: exactly one bit of an_i is 0.
  - All anodes high, or two or more anodes low, is not eligible.
  - A non-eligible cycle clears the stable counter and the captured flag.
  - A non-eligible cycle does not touch the timeout counter.
- Stability:
  - An eligible cycle whose {an,ct} equals the previous cycle increments the stable counter (saturating).
  - An eligible cycle whose {an,ct} differs loads the counter with 1 and clears the captured flag.
- Capture:
  - Occurs in the cycle the counter reaches STABLE_CYCLES while the captured flag is 0.
  - The captured flag is then set, so one steady dwell yields exactly one capture.
- Decode, using active-high segment patterns ~ct[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 = blank: nibble 0, blank bit set.
  - Any other pattern: nibble 0, slot error bit set.
- Slot storage on capture: nibble, blank bit, dp bit and error bit go into slot k, and seen[k] is set.
  - Recapturing a digit already seen overwrites that slot; this is not an error.
- Frame completion:
  - On the capture that makes seen all ones, word_o, the masks and err_o update and word_valid_o pulses on the next clock edge. Latency is 1 cycle after capture.
  - The seen mask clears at the same time.
  - Outputs hold their values until the next frame completes.
- Timeout:
  - The counter increments every cycle in which seen is not 0, and clears on each capture.
  - When it reaches TIMEOUT_CYCLES: timeout_o pulses, seen clears, word_o is unchanged.
  - If completion and timeout fall in the same cycle, completion wins and there is no timeout pulse.
- Counter widths: stable counter uses $clog2(STABLE_CYCLES+1) bits; timeout counter uses $clog2(TIMEOUT_CYCLES+1) bits.

Optional Feature:
- Macro: SEG7_DP_CAPTURE_EN.
- Defined: ct_i[7] is captured per slot and reported on dp_mask_o, and it takes part in the stability comparison.
- Undefined: dp_mask_o is tied to 0, and ct_i[7] is ignored both for stability and for decode.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment pattern constant array;
  - SEG_BLANK = 7'h00;
  - a typedef seg_slot_t struct {nibble, blank, dp, bad}.
- One sub-module, seg7_pattern_decode: combinational, 7-bit active-high pattern in, {nibble, blank, bad} out.

Test Plan:
- Frame capture: scan 0x12345678, digit 7 first, each digit held 10 cycles, 2-cycle all-high gap between digits -> one word_valid_o with word_o=0x12345678, err_o=0, blank_mask_o=0x00.
- Glitch rejection: each digit held only 3 cycles with STABLE_CYCLES=4 -> no capture and no word_valid_o. Holding digit 3 for 20 cycles -> exactly one capture.
- Bad pattern and blank: digit 2 CT=8'hFF (blank), digit 5 active-high pattern 0x01, others valid -> word_valid_o with err_o=1, blank_mask_o=0x04, nibbles 2 and 5 = 0.
- Illegal anode patterns: an_i=8'b11110011 for 50 cycles mid-frame -> no capture, frame still completes afterwards with the correct word.
- Timeout: TIMEOUT_CYCLES=100, capture 3 digits then hold all anodes high -> timeout_o pulses 100 cycles after the last capture; a following full scan yields a normal frame.
- Reset mid-frame: rst high for 1 cycle after 5 captures -> all outputs 0, and the next word_valid_o requires all 8 digits to be captured again.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment pattern table and per-digit slot record for the scan decoder
package seg7_pkg;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       dp;
        logic       bad;
    } seg_slot_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps an active-high 7-segment pattern back to its hex nibble
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    // table lookup; anything that is neither a glyph nor blank is flagged bad
    always_comb begin
        nibble = '0;
        blank  = pattern == SEG_BLANK;
        bad    = pattern != SEG_BLANK;
        for (int i = 0; i < 16; i++)
            if (pattern == SEG_PATTERNS[i]) begin
                nibble = 4'(i);
                bad    = 1'b0;
            end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reassembles scanned AN/CT display lines into a word; SEG7_DP_CAPTURE_EN adds dp capture
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [7:0]              ct_i,
    output logic [4*NUM_DIGITS-1:0] word_o,
    output logic [NUM_DIGITS-1:0]   blank_mask_o,
    output logic [NUM_DIGITS-1:0]   dp_mask_o,
    output logic                    word_valid_o,
    output logic                    err_o,
    output logic                    timeout_o
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_DP_CAPTURE_EN
    localparam logic DP_EN = 1'b1;
`else
    localparam logic DP_EN = 1'b0;
`endif

    logic [NUM_DIGITS-1:0]   an_r, an_p, seen, seen_nxt, blank_nxt, dp_nxt;
    logic [7:0]              ct_r, ct_p;
    logic [SW-1:0]           stable_cnt, stable_nxt;
    logic [TW-1:0]           tcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] word_nxt;
    logic [6:0]              seg_on;
    logic [3:0]              dec_nibble;
    logic                    dec_blank, dec_bad;
    logic                    captured, eligible, same, capture, complete, timeout_hit, err_nxt;
    seg_slot_t               slots [NUM_DIGITS];
    seg_slot_t               cur, frame;

    assign seg_on = ~ct_r[6:0];

    seg7_pattern_decode u_dec (
        .pattern (seg_on),
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .bad     (dec_bad)
    );

    // stability tracking, capture decision and the frame as it would look after this capture
    always_comb begin
        eligible    = $onehot(~an_r);
        same        = {an_r, ct_r} == {an_p, ct_p};
        stable_nxt  = !eligible ? '0 : !same ? SW'(1) :
                      stable_cnt == SW'(STABLE_CYCLES) ? stable_cnt : stable_cnt + 1'b1;
        capture     = eligible && stable_nxt == SW'(STABLE_CYCLES) && !(captured && same);
        idx         = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (!an_r[k]) idx = IW'(k);
        cur         = '{nibble: dec_nibble, blank: dec_blank, dp: DP_EN & ~ct_r[7], bad: dec_bad};
        seen_nxt    = capture ? seen | (NUM_DIGITS'(1) << idx) : seen;
        complete    = capture && &seen_nxt;
        timeout_hit = !capture && |seen && tcnt == TW'(TIMEOUT_CYCLES - 1);
        err_nxt     = 1'b0;
        word_nxt    = '0;
        blank_nxt   = '0;
        dp_nxt      = '0;
        frame       = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            frame              = (capture && idx == IW'(k)) ? cur : slots[k];
            word_nxt[4*k +: 4] = frame.nibble;
            blank_nxt[k]       = frame.blank;
            dp_nxt[k]          = frame.dp;
            err_nxt            = err_nxt | frame.bad;
        end
    end

    // input sampling, slot storage, frame/timeout bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r         <= '1;
            an_p         <= '1;
            ct_r         <= '1;
            ct_p         <= '1;
            stable_cnt   <= '0;
            captured     <= 1'b0;
            tcnt         <= '0;
            seen         <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) slots[k] <= '0;
            word_o       <= '0;
            blank_mask_o <= '0;
            dp_mask_o    <= '0;
            err_o        <= 1'b0;
            word_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            an_r         <= an_i;
            ct_r         <= {ct_i[7] | ~DP_EN, ct_i[6:0]};
            an_p         <= an_r;
            ct_p         <= ct_r;
            stable_cnt   <= stable_nxt;
            captured     <= eligible && (capture || (captured && same));
            tcnt         <= (capture || timeout_hit) ? '0 : |seen ? tcnt + 1'b1 : tcnt;
            seen         <= (complete || timeout_hit) ? '0 : seen_nxt;
            word_valid_o <= complete;
            timeout_o    <= timeout_hit;
            if (capture) slots[idx] <= cur;
            if (complete) begin
                word_o       <= word_nxt;
                blank_mask_o <= blank_nxt;
                dp_mask_o    <= dp_nxt;
                err_o        <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans checked against a dwell-level reference model
module tb_seg7_scan_decoder;

    localparam int ND = 8;
    localparam int SC = 4;
    localparam int TO = 100;
    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
`ifdef SEG7_DP_CAPTURE_EN
    localparam logic [7:0] CT_MASK = 8'hFF;
`else
    localparam logic [7:0] CT_MASK = 8'h7F;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    an_i = '1;
    logic [7:0]    ct_i = '1;
    logic [31:0]   word_o;
    logic [7:0]    blank_mask_o, dp_mask_o;
    logic          word_valid_o, err_o, timeout_o;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .an_i         (an_i),
        .ct_i         (ct_i),
        .word_o       (word_o),
        .blank_mask_o (blank_mask_o),
        .dp_mask_o    (dp_mask_o),
        .word_valid_o (word_valid_o),
        .err_o        (err_o),
        .timeout_o    (timeout_o)
    );

    int n_chk, n_fail, n_step, n_wv, n_to, cap_step, to_step;

    // reference model state: a dwell is a run of identical eligible samples
    logic [7:0]  m_last_an, m_last_ct, p_an, p_ct;
    int          m_run, m_age;
    logic [7:0]  m_seen;
    logic [3:0]  m_nib [ND];
    logic        m_blank [ND];
    logic        m_dp [ND];
    logic        m_bad [ND];
    logic [31:0] e_word;
    logic [7:0]  e_blank, e_dp;
    logic        e_err, e_wv, e_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (step %0d)", tag, obs, exp, n_step);
        end
    endtask

    function automatic void model_reset();
        m_last_an = '1; m_last_ct = '1 & CT_MASK; p_an = '1; p_ct = '1;
        m_run = 0; m_age = 0; m_seen = '0;
        for (int k = 0; k < ND; k++) begin
            m_nib[k] = '0; m_blank[k] = 0; m_dp[k] = 0; m_bad[k] = 0;
        end
        e_word = '0; e_blank = '0; e_dp = '0; e_err = 0; e_wv = 0; e_to = 0;
    endfunction

    function automatic void model(input logic [7:0] an, input logic [7:0] ct);
        logic [7:0] ctm;
        logic [6:0] pat;
        logic       elig;
        int         k;
        ctm  = ct & CT_MASK;
        elig = $countones(~an) == 1;
        e_wv = 0;
        e_to = 0;
        if (elig) m_run = (an == m_last_an && ctm == m_last_ct) ? m_run + 1 : 1;
        else m_run = 0;
        m_last_an = an;
        m_last_ct = ctm;
        if (elig && m_run == SC) begin
            k = 0;
            for (int i = 0; i < ND; i++) if (!an[i]) k = i;
            pat        = ~ctm[6:0];
            m_nib[k]   = 0;
            m_blank[k] = pat == 7'h00;
            m_bad[k]   = pat != 7'h00;
            for (int i = 0; i < 16; i++)
                if (SEG[i] == pat) begin m_nib[k] = 4'(i); m_bad[k] = 0; end
            m_dp[k]   = CT_MASK[7] & ~ctm[7];
            m_seen[k] = 1'b1;
            m_age     = 0;
            cap_step  = n_step;
            if (&m_seen) begin
                e_err = 0;
                for (int i = 0; i < ND; i++) begin
                    e_word[4*i +: 4] = m_nib[i];
                    e_blank[i]       = m_blank[i];
                    e_dp[i]          = m_dp[i];
                    e_err            = e_err | m_bad[i];
                end
                e_wv   = 1;
                m_seen = '0;
            end
        end else if (m_seen != 0) begin
            m_age++;
            if (m_age == TO) begin e_to = 1; m_seen = '0; m_age = 0; end
        end
    endfunction

    task automatic check_all();
        chk("word_valid", 32'(word_valid_o), 32'(e_wv));
        chk("timeout", 32'(timeout_o), 32'(e_to));
        chk("word", word_o, e_word);
        chk("blank_mask", 32'(blank_mask_o), 32'(e_blank));
        chk("dp_mask", 32'(dp_mask_o), 32'(e_dp));
        chk("err", 32'(err_o), 32'(e_err));
    endtask

    task automatic step(input logic [7:0] an, input logic [7:0] ct);
        an_i = an;
        ct_i = ct;
        @(posedge clk);
        n_step++;
        model(p_an, p_ct);
        p_an = an;
        p_ct = ct;
        #1;
        check_all();
        if (word_valid_o === 1'b1) n_wv++;
        if (timeout_o === 1'b1) begin n_to++; to_step = n_step; end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        an_i = '1;
        ct_i = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_word", word_o, 32'h0);
        chk("rst_masks", {blank_mask_o, dp_mask_o}, 32'h0);
        chk("rst_pulses", {word_valid_o, err_o, timeout_o}, 32'h0);
    endtask

    task automatic gap(input int n);
        repeat (n) step('1, '1);
    endtask

    task automatic show(input int k, input logic [3:0] nib, input logic dp, input int hold);
        logic [7:0] an;
        an = ~(8'd1 << k);
        repeat (hold) step(an, {~dp, ~SEG[nib]});
    endtask

    task automatic scan(input logic [31:0] w, input int hi, input int lo, input int hold, input int g);
        for (int k = hi; k >= lo; k--) begin
            show(k, w[4*k +: 4], 1'b0, hold);
            gap(g);
        end
    endtask

    task automatic random_phase();
        int         r, k;
        logic [7:0] ct;
        repeat (300) begin
            r = $urandom_range(0, 19);
            if (r == 0) repeat ($urandom_range(1, 6)) step(8'($urandom), 8'($urandom));
            else begin
                k  = $urandom_range(0, ND - 1);
                ct = (r == 1) ? 8'($urandom) : {1'($urandom), ~SEG[$urandom_range(0, 15)]};
                repeat ($urandom_range(1, 8)) step(~(8'd1 << k), ct);
                gap($urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        int wv0, to0;
        logic [7:0] ctv;
        n_chk = 0; n_fail = 0; n_step = 0; n_wv = 0; n_to = 0; cap_step = 0; to_step = 0;
        model_reset();
        do_reset();

        wv0 = n_wv;
        scan(32'h12345678, 7, 0, 10, 2);
        chk("frame_count", n_wv - wv0, 1);
        chk("frame_word", word_o, 32'h12345678);
        chk("frame_err_blank", {err_o, blank_mask_o}, 32'h0);

        wv0 = n_wv; to0 = n_to;
        scan(32'h87654321, 7, 0, 3, 2);
        gap(110);
        chk("glitch_no_frame", n_wv - wv0, 0);
        chk("glitch_no_timeout", n_to - to0, 0);
        show(3, 4'h5, 1'b0, 20);
        gap(110);
        chk("dwell_one_capture", n_to - to0, 1);

        wv0 = n_wv;
        for (int k = 7; k >= 0; k--) begin
            ctv = {1'b1, ~SEG[(8 + k) % 16]};
            if (k == 2) ctv = 8'hFF;
            if (k == 5) ctv = {1'b1, ~7'h01};
            repeat (10) step(~(8'd1 << k), ctv);
            gap(2);
        end
        chk("bad_frame_count", n_wv - wv0, 1);
        chk("bad_err", 32'(err_o), 32'h1);
        chk("bad_blank_mask", 32'(blank_mask_o), 32'h04);
        chk("bad_word", word_o, 32'hFE0CB098);

        wv0 = n_wv;
        scan(32'h13579BDF, 7, 4, 10, 2);
        repeat (50) step(8'b11110011, 8'($urandom));
        scan(32'h13579BDF, 3, 0, 10, 2);
        chk("illegal_an_count", n_wv - wv0, 1);
        chk("illegal_an_word", word_o, 32'h13579BDF);

        wv0 = n_wv; to0 = n_to;
        scan(32'hCAFE0000, 7, 5, 10, 2);
        gap(120);
        chk("timeout_count", n_to - to0, 1);
        chk("timeout_latency", to_step - cap_step, TO);
        chk("timeout_word_kept", word_o, 32'h13579BDF);
        chk("timeout_no_frame", n_wv - wv0, 0);
        scan(32'h0F1E2D3C, 7, 0, 6, 1);
        chk("after_timeout_frame", n_wv - wv0, 1);
        chk("after_timeout_word", word_o, 32'h0F1E2D3C);

        scan(32'h55AA55AA, 7, 3, 10, 2);
        do_reset();
        wv0 = n_wv;
        scan(32'h55AA55AA, 2, 0, 10, 2);
        chk("reset_discards_seen", n_wv - wv0, 0);
        gap(120);
        scan(32'h55AA55AA, 7, 0, 10, 2);
        chk("reset_full_frame", n_wv - wv0, 1);
        chk("reset_full_word", word_o, 32'h55AA55AA);

        random_phase();
        gap(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
